rv_lsu: RTL

Load/store unit that executes decoded RV32I memory instructions (LB, LH, LW, LBU, LHU, SB, SH, SW) against a word-wide data memory bus. It accepts one request at a time from the execute stage using a valid/ready handshake, and checks `funct3` and alignment before any bus access. It generates byte enables and lane-replicated write data, and sign- or zero-extends load data. It drives a req/ack bus with a bounded-wait timeout and returns a single-cycle response with an error flag.

---
 rtl/rv_lsu.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/rv_lsu.sv
// RV32I load/store unit: validates and issues one memory operation at a time
// over a req/ack word bus with a bounded wait, returning a one-cycle response.
module rv_lsu #(
  parameter int BUS_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUS = 2'd1, RESP = 2'd2} state_t;

  localparam logic [15:0] TIMEOUT_LAST = 16'(BUS_TIMEOUT - 1);

  state_t      state_r, state_s;
  logic [2:0]  funct3_r, funct3_s;
  logic [1:0]  off_r, off_s;
  logic        store_r, store_s;
  logic [15:0] cnt_r, cnt_s;
  logic        req_ready_s, rsp_valid_s, rsp_error_s;
  logic [31:0] rsp_rdata_s;
  logic        mem_req_s, mem_we_s;
  logic [31:0] mem_addr_s, mem_wdata_s;
  logic [3:0]  mem_be_s;

  function automatic logic op_legal(input logic store, input logic [2:0] f3,
                                    input logic [1:0] off);
    logic ok;
    case (f3)
      3'b000:  ok = 1'b1;
      3'b001:  ok = (off[0] == 1'b0);
      3'b010:  ok = (off == 2'b00);
      3'b100:  ok = !store;
      3'b101:  ok = !store && (off[0] == 1'b0);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [3:0] byte_en(input logic [2:0] f3, input logic [1:0] off);
    logic [3:0] be;
    case (f3[1:0])
      2'b00:   be = 4'b0001 << off;
      2'b01:   be = 4'b0011 << off;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] wd);
    logic [31:0] d;
    case (f3[1:0])
      2'b00:   d = {4{wd[7:0]}};
      2'b01:   d = {2{wd[15:0]}};
      default: d = wd;
    endcase
    return d;
  endfunction

  function automatic logic [31:0] load_data(input logic [2:0] f3, input logic [1:0] off,
                                            input logic [31:0] word);
    logic [31:0] sh;
    logic [31:0] d;
    sh = word >> {off, 3'b000};
    case (f3)
      3'b000:  d = {{24{sh[7]}}, sh[7:0]};
      3'b001:  d = {{16{sh[15]}}, sh[15:0]};
      3'b010:  d = sh;
      3'b100:  d = {24'h000000, sh[7:0]};
      3'b101:  d = {16'h0000, sh[15:0]};
      default: d = 32'h0000_0000;
    endcase
    return d;
  endfunction

  // Next-state and next-output logic; every output is computed here and registered below.
  always_comb begin
    state_s     = state_r;
    funct3_s    = funct3_r;
    off_s       = off_r;
    store_s     = store_r;
    cnt_s       = cnt_r;
    req_ready_s = req_ready;
    rsp_valid_s = rsp_valid;
    rsp_error_s = rsp_error;
    rsp_rdata_s = rsp_rdata;
    mem_req_s   = mem_req;
    mem_we_s    = mem_we;
    mem_addr_s  = mem_addr;
    mem_be_s    = mem_be;
    mem_wdata_s = mem_wdata;
    case (state_r)
      IDLE: begin
        if (req_valid) begin
          funct3_s    = req_funct3;
          off_s       = req_addr[1:0];
          store_s     = req_store;
          cnt_s       = 16'd0;
          req_ready_s = 1'b0;
          if (op_legal(req_store, req_funct3, req_addr[1:0])) begin
            state_s     = BUS;
            mem_req_s   = 1'b1;
            mem_we_s    = req_store;
            mem_addr_s  = {req_addr[31:2], 2'b00};
            mem_be_s    = byte_en(req_funct3, req_addr[1:0]);
            mem_wdata_s = req_store ? store_data(req_funct3, req_wdata) : 32'h0000_0000;
          end else begin
            state_s     = RESP;
            rsp_valid_s = 1'b1;
            rsp_error_s = 1'b1;
            rsp_rdata_s = 32'h0000_0000;
          end
        end else begin
          req_ready_s = 1'b1;
        end
      end
      BUS: begin
        // Ack wins over a timeout that expires in the same cycle.
        if (mem_ack) begin
          state_s     = RESP;
          mem_req_s   = 1'b0;
          rsp_valid_s = 1'b1;
          rsp_error_s = 1'b0;
          rsp_rdata_s = store_r ? 32'h0000_0000 : load_data(funct3_r, off_r, mem_rdata);
        end else if ((BUS_TIMEOUT != 0) && (cnt_r == TIMEOUT_LAST)) begin
          state_s     = RESP;
          mem_req_s   = 1'b0;
          rsp_valid_s = 1'b1;
          rsp_error_s = 1'b1;
          rsp_rdata_s = 32'h0000_0000;
        end else begin
          cnt_s = cnt_r + 16'd1;
        end
      end
      RESP: begin
        state_s     = IDLE;
        rsp_valid_s = 1'b0;
        rsp_error_s = 1'b0;
        rsp_rdata_s = 32'h0000_0000;
        req_ready_s = 1'b1;
      end
      default: begin
        state_s     = IDLE;
        mem_req_s   = 1'b0;
        rsp_valid_s = 1'b0;
        req_ready_s = 1'b1;
      end
    endcase
  end

  // State and output registers; reset aborts any operation without a response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      funct3_r  <= 3'b000;
      off_r     <= 2'b00;
      store_r   <= 1'b0;
      cnt_r     <= 16'd0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_error <= 1'b0;
      rsp_rdata <= 32'h0000_0000;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'h0000_0000;
      mem_be    <= 4'b0000;
      mem_wdata <= 32'h0000_0000;
    end else begin
      state_r   <= state_s;
      funct3_r  <= funct3_s;
      off_r     <= off_s;
      store_r   <= store_s;
      cnt_r     <= cnt_s;
      req_ready <= req_ready_s;
      rsp_valid <= rsp_valid_s;
      rsp_error <= rsp_error_s;
      rsp_rdata <= rsp_rdata_s;
      mem_req   <= mem_req_s;
      mem_we    <= mem_we_s;
      mem_addr  <= mem_addr_s;
      mem_be    <= mem_be_s;
      mem_wdata <= mem_wdata_s;
    end
  end

endmodule
